// File: rtl/cpu_controller_pkg.sv
// Shared types and constants for the MOV/ALU controller: FSM states, instruction
// classes, decoded fields, the datapath control bundle and its Moore output map.
package cpu_pkg;
  localparam int WIDTH = 16;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_WR_REG
  } state_t;

  typedef enum logic [2:0] {
    C_MOV_IMM, C_MOV_REG, C_ADD, C_CMP, C_AND, C_MVN, C_ILL
  } iclass_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;

  typedef struct packed {
    iclass_t    cls;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } dec_t;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;

  // Datapath controls to present while sitting in state st.
  function automatic ctl_t moore_ctl(state_t st, dec_t d);
    ctl_t c;
    c = CTL_IDLE;
    case (st)
      S_GET_A: begin c.readnum = d.rn; c.loada = 1'b1; end
      S_GET_B: begin c.readnum = d.rm; c.loadb = 1'b1; end
      S_ALU: begin
        c.shift = d.sh;
        c.bsel  = 1'b0;
        if (d.cls == C_MOV_REG) begin
          c.asel  = 1'b1;
          c.aluop = 2'b00;
          c.loadc = 1'b1;
        end else begin
          c.asel  = 1'b0;
          c.aluop = d.op;
          if (d.cls == C_CMP) c.loads = 1'b1;
          else                c.loadc = 1'b1;
        end
      end
      S_WR_IMM: begin c.writenum = d.rn; c.vsel = VSEL_IMM8; c.write = 1'b1; end
      S_WR_REG: begin c.writenum = d.rd; c.vsel = VSEL_C;    c.write = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/cpu_controller_if.sv
// Bundle between CPU wrapper/datapath (master) and the controller (slave).
interface cpu_ctrl_if;
  logic [cpu_pkg::WIDTH-1:0] in;
  logic                      load;
  logic                      s;
  logic                      w;
  logic                      ill;
  logic [2:0]                readnum;
  logic [2:0]                writenum;
  logic                      write;
  logic                      loada;
  logic                      loadb;
  logic                      loadc;
  logic                      loads;
  logic                      asel;
  logic                      bsel;
  logic [1:0]                vsel;
  logic [1:0]                shift;
  logic [1:0]                ALUop;
  logic [cpu_pkg::WIDTH-1:0] sximm8;
  logic [cpu_pkg::WIDTH-1:0] sximm5;

  modport slave (
    input  in, load, s,
    output w, ill, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );

  modport master (
    output in, load, s,
    input  w, ill, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, ALUop, sximm8, sximm5
  );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational split of the instruction register into fields, instruction
// class and sign-extended immediates.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [WIDTH-1:0] ir_i,
  output dec_t             dec_o,
  output logic [WIDTH-1:0] sximm8_o,
  output logic [WIDTH-1:0] sximm5_o
);
  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir_i[15:13];
  assign op     = ir_i[12:11];

  always_comb begin
    dec_o.op  = op;
    dec_o.rn  = ir_i[10:8];
    dec_o.rd  = ir_i[7:5];
    dec_o.sh  = ir_i[4:3];
    dec_o.rm  = ir_i[2:0];
    dec_o.cls = C_ILL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      dec_o.cls = C_MOV_IMM;
      else if (op == OP_MOV_REG) dec_o.cls = C_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  dec_o.cls = C_ADD;
        OP_CMP:  dec_o.cls = C_CMP;
        OP_AND:  dec_o.cls = C_AND;
        default: dec_o.cls = C_MVN;
      endcase
    end
  end

  assign sximm8_o = {{(WIDTH-8){ir_i[7]}}, ir_i[7:0]};
  assign sximm5_o = {{(WIDTH-5){ir_i[4]}}, ir_i[4:0]};
endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore sequencer for the MOV/ALU subset; control
// outputs are registered for the state being entered so they change only on clk.
module cpu_controller
  import cpu_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  cpu_ctrl_if.slave bus
);
  logic [WIDTH-1:0] ir_q;
  state_t           state_q;
  logic             ill_q;
  logic             w_q;
  ctl_t             ctl_q;
  dec_t             dec;
  logic [WIDTH-1:0] sximm8;
  logic [WIDTH-1:0] sximm5;

  instr_decoder u_dec (
    .ir_i     (ir_q),
    .dec_o    (dec),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
      ill_q   <= 1'b0;
      w_q     <= 1'b1;
      ctl_q   <= CTL_IDLE;
    end else begin
      ctl_q <= CTL_IDLE;
      case (state_q)
        S_WAIT: begin
          if (bus.load) ir_q <= bus.in;
          if (bus.s) begin
            state_q <= S_DECODE;
            w_q     <= 1'b0;
          end
        end
        S_DECODE: begin
          case (dec.cls)
            C_MOV_IMM: begin
              state_q <= S_WR_IMM;
              ctl_q   <= moore_ctl(S_WR_IMM, dec);
            end
            C_ADD, C_CMP, C_AND: begin
              state_q <= S_GET_A;
              ctl_q   <= moore_ctl(S_GET_A, dec);
            end
            C_MOV_REG, C_MVN: begin
              state_q <= S_GET_B;
              ctl_q   <= moore_ctl(S_GET_B, dec);
            end
            default: begin
              state_q <= S_WAIT;
              ill_q   <= 1'b1;
              w_q     <= 1'b1;
            end
          endcase
        end
        S_GET_A: begin
          state_q <= S_GET_B;
          ctl_q   <= moore_ctl(S_GET_B, dec);
        end
        S_GET_B: begin
          state_q <= S_ALU;
          ctl_q   <= moore_ctl(S_ALU, dec);
        end
        S_ALU: begin
          // CMP only updates status, so it has no writeback state.
          if (dec.cls == C_CMP) begin
            state_q <= S_WAIT;
            w_q     <= 1'b1;
          end else begin
            state_q <= S_WR_REG;
            ctl_q   <= moore_ctl(S_WR_REG, dec);
          end
        end
        default: begin
          state_q <= S_WAIT;
          w_q     <= 1'b1;
        end
      endcase
    end
  end

  assign bus.w        = w_q;
  assign bus.ill      = ill_q;
  assign bus.readnum  = ctl_q.readnum;
  assign bus.writenum = ctl_q.writenum;
  assign bus.write    = ctl_q.write;
  assign bus.loada    = ctl_q.loada;
  assign bus.loadb    = ctl_q.loadb;
  assign bus.loadc    = ctl_q.loadc;
  assign bus.loads    = ctl_q.loads;
  assign bus.asel     = ctl_q.asel;
  assign bus.bsel     = ctl_q.bsel;
  assign bus.vsel     = ctl_q.vsel;
  assign bus.shift    = ctl_q.shift;
  assign bus.ALUop    = ctl_q.aluop;
  assign bus.sximm8   = sximm8;
  assign bus.sximm5   = sximm5;
endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench: each instruction pushes its expected per-cycle control trace
// into a scoreboard, which is popped and checked one cycle at a time.
module tb_cpu_controller;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  cpu_ctrl_if bus ();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string      tag;
    logic       w, ill;
    logic       write, loada, loadb, loadc, loads;
    logic [2:0] rnum, wnum;
    logic [1:0] vsel, shift, aluop;
    logic       asel;
    bit         alu;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic exp_ill  = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t idle(input string tag, input logic w);
    exp_t e;
    e.tag = tag; e.w = w; e.ill = exp_ill;
    e.write = 1'b0; e.loada = 1'b0; e.loadb = 1'b0; e.loadc = 1'b0; e.loads = 1'b0;
    e.rnum = 3'd0; e.wnum = 3'd0; e.vsel = 2'b00; e.shift = 2'b00; e.aluop = 2'b00;
    e.asel = 1'b0; e.alu = 1'b0;
    return e;
  endfunction

  // Reference sequence built from the instruction-set table.
  task automatic model_push(input logic [15:0] word);
    logic [2:0] opc;
    logic [1:0] op, sh;
    logic [2:0] rn, rd, rm;
    bit         is_movi, is_movr, is_alu, is_cmp;
    exp_t       e;
    opc = word[15:13]; op = word[12:11]; rn = word[10:8];
    rd  = word[7:5];   sh = word[4:3];   rm = word[2:0];
    is_movi = (opc == 3'b110) && (op == 2'b10);
    is_movr = (opc == 3'b110) && (op == 2'b00);
    is_alu  = (opc == 3'b101);
    is_cmp  = is_alu && (op == 2'b01);
    sb.push_back(idle("DECODE", 1'b0));
    if (is_movi) begin
      e = idle("WR_IMM", 1'b0); e.write = 1'b1; e.wnum = rn; e.vsel = 2'b10;
      sb.push_back(e);
    end else if (is_movr || is_alu) begin
      if (is_alu && op != 2'b11) begin
        e = idle("GET_A", 1'b0); e.loada = 1'b1; e.rnum = rn;
        sb.push_back(e);
      end
      e = idle("GET_B", 1'b0); e.loadb = 1'b1; e.rnum = rm;
      sb.push_back(e);
      e = idle("ALU", 1'b0); e.alu = 1'b1; e.shift = sh;
      e.asel  = is_movr;
      e.aluop = is_movr ? 2'b00 : op;
      if (is_cmp) e.loads = 1'b1;
      else        e.loadc = 1'b1;
      sb.push_back(e);
      if (!is_cmp) begin
        e = idle("WR_REG", 1'b0); e.write = 1'b1; e.wnum = rd; e.vsel = 2'b00;
        sb.push_back(e);
      end
    end else begin
      exp_ill = 1'b1;
    end
    sb.push_back(idle("WAIT", 1'b1));
  endtask

  task automatic compare(input exp_t e);
    check({e.tag, " w/ill/en"},
          {9'b0, bus.w, bus.ill, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads},
          {9'b0, e.w, e.ill, e.write, e.loada, e.loadb, e.loadc, e.loads});
    if (e.loada || e.loadb)
      check({e.tag, " readnum"}, 16'(bus.readnum), 16'(e.rnum));
    if (e.write)
      check({e.tag, " writenum/vsel"}, {11'b0, bus.writenum, bus.vsel}, {11'b0, e.wnum, e.vsel});
    if (e.alu)
      check({e.tag, " shift/aluop/asel/bsel"},
            {8'b0, bus.shift, bus.ALUop, bus.asel, bus.bsel, 2'b0},
            {8'b0, e.shift, e.aluop, e.asel, 1'b0, 2'b0});
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run(input logic [15:0] word, input bit split, input bit midload);
    if (split) begin
      bus.in = word; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
    end
    bus.in = word; bus.load = !split; bus.s = 1'b1;
    model_push(word);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    for (int cyc = 0; sb.size() > 0; cyc++) begin
      if (midload) begin
        bus.load = (cyc == 1);
        bus.in   = (cyc == 1) ? 16'hE000 : word;
      end
      compare(sb.pop_front());
      @(negedge clk);
    end
    bus.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in = '0; bus.load = 1'b0; bus.s = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    compare(idle("reset", 1'b1));
    check("reset vsel/shift/aluop", {10'b0, bus.vsel, bus.shift, bus.ALUop}, 16'h0000);
    check("reset sximm8", bus.sximm8, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    run(16'hD007, 1'b1, 1'b0);
    check("D007 sximm8", bus.sximm8, 16'h0007);
    run(16'hD102, 1'b0, 1'b0);
    run(16'hA148, 1'b0, 1'b0);
    check("A148 sximm5", bus.sximm5, 16'h0008);
    run(16'hD4FF, 1'b1, 1'b0);
    check("D4FF sximm8", bus.sximm8, 16'hFFFF);
    check("D4FF sximm5", bus.sximm5, 16'hFFFF);
    run(16'hA801, 1'b0, 1'b0);
    run(16'hB860, 1'b0, 1'b0);
    run(16'hC06A, 1'b1, 1'b0);
    run(16'hB291, 1'b0, 1'b0);
    run(16'hE000, 1'b0, 1'b0);
    run(16'hC800, 1'b0, 1'b0);
    run(16'hA148, 1'b0, 1'b1);
    check("midload sximm8", bus.sximm8, 16'h0048);

    // Abort an ADD while it sits in GET_B.
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    model_push(16'hA148);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      compare(sb.pop_front());
      @(negedge clk);
    end
    compare(sb.pop_front());
    sb.delete();
    reset_n = 1'b0;
    exp_ill = 1'b0;
    #1;
    compare(idle("abort", 1'b1));
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compare(idle("post-abort", 1'b1));
    end
    check("post-abort sximm8", bus.sximm8, 16'h0000);

    run(16'hD007, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
